counter_scan_master: RTL



---
 rtl/counter_scan_master.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/counter_scan_master.sv
// counter_scan_master: steps an output level, gates the pulse counter once per
// step over its register bus, reads back count/time and streams one record per step.
module counter_scan_master #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SETTLE_CYCLES  = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 300000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_start,
    input  logic                  abort,
    input  logic [7:0]            cfg_steps,
    input  logic [7:0]            cfg_gate_sec,
    input  logic [15:0]           cfg_level_start,
    input  logic [15:0]           cfg_level_inc,
    output logic [7:0]            ctr_addr,
    output logic [DATA_WIDTH-1:0] ctr_data_in,
    output logic                  ctr_we,
    input  logic [DATA_WIDTH-1:0] ctr_data_out,
    output logic                  ctr_start,
    input  logic                  ctr_stop,
    output logic [15:0]           scan_level,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            res_step,
    output logic [15:0]           res_level,
    output logic [31:0]           res_count,
    output logic [31:0]           res_time,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CNT_W     = 32;
    localparam logic [7:0]  GATE_ADDR = 8'h27;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_LEVEL,
        S_SETTLE,
        S_WR_GATE,
        S_WR_HOLD,
        S_START,
        S_WAIT_STOP_HI,
        S_WAIT_STOP_LO,
        S_RD_ADDR,
        S_RD_HOLD,
        S_RD_SAMPLE,
        S_PUSH,
        S_NEXT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_byte;
    logic [2:0]       w_byte_nxt;
    logic [7:0]       r_steps;
    logic [7:0]       r_gate;
    logic [15:0]      r_inc;
    logic [7:0]       r_step;
    logic [15:0]      r_level;
    logic [63:0]      r_rec;

    logic             w_timeout;
    logic             w_done_nxt;
    logic             w_accept;
    logic [7:0]       w_addr_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_we_nxt;
    logic             w_start_nxt;
    logic             w_busy_nxt;
    logic             w_valid_nxt;

    // Readback address for byte b: count at 0x28..0x31, time at 0x32..0x35 (hex gap is intentional)
    function automatic logic [7:0] rd_addr(input logic [2:0] b);
        logic [7:0] a;
        case (b)
            3'd0:    a = 8'h28;
            3'd1:    a = 8'h29;
            3'd2:    a = 8'h30;
            3'd3:    a = 8'h31;
            3'd4:    a = 8'h32;
            3'd5:    a = 8'h33;
            3'd6:    a = 8'h34;
            default: a = 8'h35;
        endcase
        return a;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && run_start;
    assign res_count = r_rec[31:0];
    assign res_time  = r_rec[63:32];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, byte index, timeout and done decisions; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_timeout   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_start) begin
                    if (cfg_steps == 8'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SET_LEVEL;
                    end
                end
            end
            S_SET_LEVEL: w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_WR_GATE;
            end
            S_WR_GATE: w_state_nxt = S_WR_HOLD;
            S_WR_HOLD: begin
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_START;
            end
            S_START: w_state_nxt = S_WAIT_STOP_HI;
            S_WAIT_STOP_HI: begin
                if (ctr_stop) begin
                    w_state_nxt = S_WAIT_STOP_LO;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_STOP_LO: begin
                if (!ctr_stop) begin
                    w_state_nxt = S_RD_ADDR;
                    w_byte_nxt  = 3'd0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_ADDR: w_state_nxt = S_RD_HOLD;
            S_RD_HOLD: w_state_nxt = S_RD_SAMPLE;
            S_RD_SAMPLE: begin
                if (r_byte == 3'd7) begin
                    w_state_nxt = S_PUSH;
                end else begin
                    w_state_nxt = S_RD_ADDR;
                    w_byte_nxt  = r_byte + 3'd1;
                end
            end
            S_PUSH: begin
                if (res_valid && res_ready) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (r_step == r_steps - 8'd1) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_SET_LEVEL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    // Bus/stream values for the state being entered, so the registered outputs line up with it
    always_comb begin
        w_addr_nxt  = 8'h00;
        w_data_nxt  = 8'h00;
        w_we_nxt    = 1'b0;
        w_start_nxt = 1'b0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_valid_nxt = (w_state_nxt == S_PUSH);
        case (w_state_nxt)
            S_WR_GATE: begin
                w_addr_nxt = GATE_ADDR;
                w_data_nxt = r_gate;
                w_we_nxt   = 1'b1;
            end
            S_WR_HOLD: begin
                w_addr_nxt = GATE_ADDR;
                w_data_nxt = r_gate;
            end
            S_START:                          w_start_nxt = 1'b1;
            S_RD_ADDR, S_RD_HOLD, S_RD_SAMPLE: w_addr_nxt = rd_addr(w_byte_nxt);
            default: ;
        endcase
    end

    // Registered outputs and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_addr    <= 8'h00;
            ctr_data_in <= '0;
            ctr_we      <= 1'b0;
            ctr_start   <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            ctr_addr    <= w_addr_nxt;
            ctr_data_in <= DATA_WIDTH'(w_data_nxt);
            ctr_we      <= w_we_nxt;
            ctr_start   <= w_start_nxt;
            busy        <= w_busy_nxt;
            res_valid   <= w_valid_nxt;
            done        <= w_done_nxt;
            if (w_accept) begin
                error <= 1'b0;
            end else if (w_timeout) begin
                error <= 1'b1;
            end
        end
    end

    // Shared settle / hold / stop-wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_SET_LEVEL, S_WR_GATE, S_START:   r_cnt <= '0;
                S_WAIT_STOP_HI:                    r_cnt <= ctr_stop ? '0 : r_cnt + CNT_W'(1);
                S_SETTLE, S_WR_HOLD, S_WAIT_STOP_LO: r_cnt <= r_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Scan config, step/level bookkeeping and record capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_steps    <= 8'h00;
            r_gate     <= 8'h00;
            r_inc      <= 16'h0000;
            r_step     <= 8'h00;
            r_level    <= 16'h0000;
            r_byte     <= 3'd0;
            r_rec      <= 64'h0;
            scan_level <= 16'h0000;
            res_step   <= 8'h00;
            res_level  <= 16'h0000;
        end else begin
            r_byte <= w_byte_nxt;
            if (w_accept) begin
                r_steps <= cfg_steps;
                r_gate  <= cfg_gate_sec;
                r_inc   <= cfg_level_inc;
                r_step  <= 8'h00;
                r_level <= cfg_level_start;
            end
            if ((r_state == S_NEXT) && (w_state_nxt == S_SET_LEVEL)) begin
                r_step  <= r_step + 8'd1;
                r_level <= r_level + r_inc;
            end
            if (r_state == S_SET_LEVEL) begin
                scan_level <= r_level;
            end
            if (r_state == S_RD_SAMPLE) begin
                r_rec[6'({r_byte, 3'b000}) +: 8] <= 8'(ctr_data_out);
            end
            if ((r_state == S_RD_SAMPLE) && (w_state_nxt == S_PUSH)) begin
                res_step  <= r_step;
                res_level <= r_level;
            end
        end
    end

endmodule
